// File: rtl/pack_arbiter.sv
// -----------------------------------------------------------------------------
// pack_arbiter
//   Round-robin arbiter that lets NUM_SRC word sources share one packer input.
//   A granted source owns the packer for a whole payload of PAYLOAD_WORDS
//   transfers. After the payload it releases the packer, and the next owner is
//   picked in one idle arbitration cycle.
//
//   Optional feature (macro PACK_ARB_TIMEOUT_EN): if the owner starves a ready
//   packer for TIMEOUT_CYCLES cycles, the rest of the payload is padded with
//   FILL_WORD. With the macro undefined, a stalled owner is waited on forever
//   and o_timeout is tied to 0.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset_n      asynchronous active-low reset
//   i_data         source words, source k at [k*SIZE_INPUT_BIT +: SIZE_INPUT_BIT]
//   i_valid        per-source word valid
//   o_ready        per-source ready (only the owner can see 1)
//   o_data         word to the packer
//   o_valid        word valid to the packer
//   i_ready        packer ready
//   o_grant        one-hot payload owner, zero when idle
//   o_packet_done  pulse on the last payload word transfer
//   o_timeout      pulse on the cycle the FSM enters padding
// -----------------------------------------------------------------------------
module pack_arbiter #(
  parameter int                        NUM_SRC        = 2,
  parameter int                        SIZE_INPUT_BIT = 8,
  parameter int                        PAYLOAD_WORDS  = 243,
  parameter int                        TIMEOUT_CYCLES = 1024,
  parameter logic [SIZE_INPUT_BIT-1:0] FILL_WORD      = '0
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [NUM_SRC*SIZE_INPUT_BIT-1:0] i_data,
  input  logic [NUM_SRC-1:0]                i_valid,
  output logic [NUM_SRC-1:0]                o_ready,
  output logic [SIZE_INPUT_BIT-1:0]         o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [NUM_SRC-1:0]                o_grant,
  output logic                              o_packet_done,
  output logic                              o_timeout
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_SRC - 1);

`ifdef PACK_ARB_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, PAD} state_t;
`else
  typedef enum logic {IDLE, GRANT} state_t;

  // Padding-only parameters have no hardware in this build.
  logic unused_cfg;
  assign unused_cfg = ^{FILL_WORD, TIMEOUT_CYCLES[0]};
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   last_q, last_d;    // previous owner, start of the RR search
  logic [IDX_W-1:0]   gidx_q, gidx_d;    // current owner as an index
  logic [NUM_SRC-1:0] grant_q, grant_d;  // current owner as one-hot
`ifdef PACK_ARB_TIMEOUT_EN
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             rr_hit;
  logic             xfer;

  assign o_grant = grant_q;

  // Round-robin search: first requester strictly after last_q, wrapping.
  always_comb begin
    rr_idx = last_q;
    rr_hit = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_SRC);
      if (!rr_hit && i_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which is what would otherwise infer a latch.
    state_d       = state_q;
    count_d       = count_q;
    last_d        = last_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    o_data        = '0;
    o_valid       = 1'b0;
    o_ready       = '0;
    o_packet_done = 1'b0;
    o_timeout     = 1'b0;
    xfer          = 1'b0;
`ifdef PACK_ARB_TIMEOUT_EN
    stall_d       = stall_q;
`endif

    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          state_d = GRANT;
          gidx_d  = rr_idx;
          grant_d = NUM_SRC'(1) << rr_idx;
        end
      end

      GRANT: begin
        o_data  = i_data[gidx_q*SIZE_INPUT_BIT +: SIZE_INPUT_BIT];
        o_valid = i_valid[gidx_q];
        o_ready = i_ready ? grant_q : '0;
        xfer    = o_valid & i_ready;
`ifdef PACK_ARB_TIMEOUT_EN
        // Only cycles where the packer waits on the owner count as a stall.
        if (xfer) begin
          stall_d = '0;
        end else if (i_ready) begin
          if (stall_q == STALL_LAST) begin
            o_timeout = 1'b1;
            stall_d   = '0;
            state_d   = PAD;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
`endif
      end

`ifdef PACK_ARB_TIMEOUT_EN
      PAD: begin
        o_data  = FILL_WORD;
        o_valid = 1'b1;
        xfer    = i_ready;
      end
`endif

      default: state_d = IDLE;
    endcase

    // Payload accounting is shared by GRANT and PAD.
    if (xfer) begin
      if (count_q == LAST_CNT) begin
        o_packet_done = 1'b1;
        count_d       = '0;
        last_d        = gidx_q;
        grant_d       = '0;
        state_d       = IDLE;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= LAST_SRC;
      gidx_q  <= '0;
      grant_q <= '0;
`ifdef PACK_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
`ifdef PACK_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_pack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pack_arbiter
//   Directed bench for pack_arbiter with PAYLOAD_WORDS=4, two sources and
//   TIMEOUT_CYCLES=8. A cycle-level reference model built from the arbitration
//   rules checks every output on every falling edge; directed phases then pin
//   the transfer logs against hand-computed literal sequences.
// -----------------------------------------------------------------------------
module tb_pack_arbiter;

  localparam int         NUM_SRC = 2;
  localparam int         W       = 8;
  localparam int         P       = 4;
  localparam int         TO      = 8;
  localparam logic [7:0] FILL    = 8'h00;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_SRC*W-1:0]   i_data = '0;
  logic [NUM_SRC-1:0]     i_valid = '0;
  logic [NUM_SRC-1:0]     o_ready;
  logic [W-1:0]           o_data;
  logic                   o_valid;
  logic                   i_ready = 1'b0;
  logic [NUM_SRC-1:0]     o_grant;
  logic                   o_packet_done;
  logic                   o_timeout;

  pack_arbiter #(
    .NUM_SRC(NUM_SRC), .SIZE_INPUT_BIT(W), .PAYLOAD_WORDS(P),
    .TIMEOUT_CYCLES(TO), .FILL_WORD(FILL)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_grant(o_grant), .o_packet_done(o_packet_done), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Source word queues and packer-side transfer logs.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] log_data[$];
  logic       log_done[$];
  logic [1:0] log_grant[$];
  int         log_cyc[$];
  int         timeout_cnt = 0;
  int         cyc = 0;
  logic       rdy = 1'b1;

  task automatic drive();
    i_valid[0]   = (q0.size() > 0);
    i_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    i_valid[1]   = (q1.size() > 0);
    i_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    i_ready      = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_done.delete();
    log_grant.delete();
    log_cyc.delete();
    timeout_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    rdy = 1'b1;
    drive();
    step();
    step();
    clear_logs();
    rst_n = 1'b1;
    drive();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(log_data.size() >= n), 32'd1);
  endtask

  // Reference model state: owner index (-1 when nobody owns the packer),
  // words moved in this payload, previous owner, stall length, padding flag.
  int   m_owner = -1;
  int   m_count = 0;
  int   m_last  = NUM_SRC - 1;
  int   m_stall = 0;
  bit   m_pad   = 1'b0;
  bit   moved, stall;
  logic [1:0] e_grant, e_ready;
  logic [7:0] e_data;
  logic       e_valid, e_done, e_to;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_grant", 32'(o_grant), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_data",  32'(o_data),  32'd0);
      check("rst_done",  32'(o_packet_done), 32'd0);
      check("rst_tmo",   32'(o_timeout), 32'd0);
      m_owner = -1; m_count = 0; m_last = NUM_SRC - 1;
      m_stall = 0;  m_pad = 1'b0; prev_hold = 1'b0;
    end else begin
      e_grant = '0; e_ready = '0; e_data = '0;
      e_valid = 1'b0; e_done = 1'b0; e_to = 1'b0;
      moved = 1'b0; stall = 1'b0;
      if (m_owner >= 0) begin
        e_grant = 2'(1 << m_owner);
        if (m_pad) begin
          e_valid = 1'b1;
          e_data  = FILL;
        end else begin
          e_valid = i_valid[m_owner];
          e_data  = i_data[m_owner*W +: W];
          e_ready = i_ready ? e_grant : 2'b00;
        end
        moved  = e_valid && i_ready;
        e_done = moved && (m_count == P - 1);
`ifdef PACK_ARB_TIMEOUT_EN
        stall = !m_pad && i_ready && !e_valid;
        e_to  = stall && (m_stall + 1 == TO);
`endif
      end

      check("grant", 32'(o_grant), 32'(e_grant));
      check("valid", 32'(o_valid), 32'(e_valid));
      check("ready", 32'(o_ready), 32'(e_ready));
      check("data",  32'(o_data),  32'(e_data));
      check("done",  32'(o_packet_done), 32'(e_done));
      check("timeout", 32'(o_timeout), 32'(e_to));
      if (prev_hold && o_valid) check("data_hold", 32'(o_data), 32'(prev_data));
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;

      if (o_valid && i_ready) begin
        log_data.push_back(o_data);
        log_done.push_back(o_packet_done);
        log_grant.push_back(o_grant);
        log_cyc.push_back(cyc);
      end
      if (o_timeout) timeout_cnt++;
      if (i_valid[0] && o_ready[0]) void'(q0.pop_front());
      if (i_valid[1] && o_ready[1]) void'(q1.pop_front());

      if (m_owner < 0) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (m_owner < 0 && i_valid[(m_last + k) % NUM_SRC]) m_owner = (m_last + k) % NUM_SRC;
        end
      end else if (moved) begin
        m_stall = 0;
        m_count++;
        if (m_count == P) begin
          m_count = 0;
          m_last  = m_owner;
          m_owner = -1;
          m_pad   = 1'b0;
        end
      end else if (stall) begin
        m_stall++;
        if (m_stall == TO) begin
          m_pad   = 1'b1;
          m_stall = 0;
        end
      end
    end
  end

  initial begin
    drive();

    // Single source, two payloads: data order, done position, re-grant.
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) q0.push_back(8'h21 + 8'(i));
    drive();
    wait_log(8, 40, "p1_wait");
    if (log_data.size() >= 8) begin
      check("p1_d0", 32'(log_data[0]), 32'h11);
      check("p1_d1", 32'(log_data[1]), 32'h12);
      check("p1_d2", 32'(log_data[2]), 32'h13);
      check("p1_d3", 32'(log_data[3]), 32'h14);
      check("p1_done", 32'({log_done[0], log_done[1], log_done[2], log_done[3]}), 32'b0001);
      for (int i = 0; i < 8; i++) check("p1_grant", 32'(log_grant[i]), 32'b01);
      check("p1_gap", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
      check("p1_d4", 32'(log_data[4]), 32'h21);
      check("p1_done2", 32'(log_done[7]), 32'd1);
    end

    // Two continuous requesters: grant order 01,10,01 with one idle cycle.
    do_reset();
    for (int i = 0; i < 8; i++) q0.push_back(8'hA1 + 8'(i));
    for (int i = 0; i < 8; i++) q1.push_back(8'hB1 + 8'(i));
    drive();
    wait_log(12, 60, "p2_wait");
    if (log_data.size() >= 12) begin
      check("p2_g0", 32'(log_grant[3]),  32'b01);
      check("p2_g1", 32'(log_grant[7]),  32'b10);
      check("p2_g2", 32'(log_grant[11]), 32'b01);
      check("p2_done", 32'({log_done[3], log_done[7], log_done[11]}), 32'b111);
      check("p2_gap0", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
      check("p2_gap1", 32'(log_cyc[8] - log_cyc[7]), 32'd2);
      check("p2_b1", 32'(log_data[4]), 32'hB1);
      check("p2_a5", 32'(log_data[8]), 32'hA5);
    end

    // Packer ready toggling: no lost or duplicated word.
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(8'h31 + 8'(i));
    drive();
    for (int i = 0; i < 12; i++) begin
      rdy = (i % 2 == 0);
      step();
    end
    rdy = 1'b1;
    wait_log(4, 20, "p3_wait");
    for (int i = 0; i < 4; i++) step();
    check("p3_count", 32'(log_data.size()), 32'd4);
    if (log_data.size() >= 4) begin
      check("p3_seq", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'h31323334);
      check("p3_done", 32'(log_done[3]), 32'd1);
    end

    // Reset mid-payload after two words.
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(8'h41 + 8'(i));
    drive();
    wait_log(2, 20, "p4_wait");
    check("p4_pre_grant", 32'(o_grant), 32'b01);
    rst_n = 1'b0;
    #1;
    check("p4_rst_grant", 32'(o_grant), 32'd0);
    check("p4_rst_valid", 32'(o_valid), 32'd0);
    check("p4_rst_ready", 32'(o_ready), 32'd0);
    check("p4_rst_data",  32'(o_data),  32'd0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 4; i++) q0.push_back(8'h51 + 8'(i));
    for (int i = 0; i < 4; i++) q1.push_back(8'h61 + 8'(i));
    drive();
    step();
    clear_logs();
    rst_n = 1'b1;
    drive();
    wait_log(4, 20, "p4_wait2");
    if (log_data.size() >= 4) begin
      check("p4_first", 32'(log_data[0]), 32'h51);
      check("p4_grant", 32'(log_grant[0]), 32'b01);
      check("p4_done", 32'({log_done[0], log_done[1], log_done[2], log_done[3]}), 32'b0001);
      check("p4_last", 32'(log_data[3]), 32'h54);
    end

    // Owner stops after one word.
    do_reset();
    q0.push_back(8'h71);
    drive();
    wait_log(1, 10, "p5_wait");
    for (int i = 0; i < 100; i++) step();
`ifdef PACK_ARB_TIMEOUT_EN
    check("p5_tmo_cnt", 32'(timeout_cnt), 32'd1);
    check("p5_count", 32'(log_data.size()), 32'd4);
    if (log_data.size() >= 4) begin
      check("p5_seq", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'h71000000);
      check("p5_done", 32'({log_done[0], log_done[1], log_done[2], log_done[3]}), 32'b0001);
      check("p5_tmo_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd9);
    end
`else
    check("p5_tmo_cnt", 32'(timeout_cnt), 32'd0);
    check("p5_count", 32'(log_data.size()), 32'd1);
    check("p5_hold_grant", 32'(o_grant), 32'b01);
    check("p5_hold_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 3; i++) q0.push_back(8'h72 + 8'(i));
    drive();
    wait_log(4, 20, "p5_wait2");
    if (log_data.size() >= 4) begin
      check("p5_seq", {log_data[0], log_data[1], log_data[2], log_data[3]}, 32'h71727374);
      check("p5_done", 32'(log_done[3]), 32'd1);
    end
`endif

    for (int i = 0; i < 3; i++) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
